alu_bist: RTL and testbench

//   Built-in self-test engine that drives the EX-stage ALU operand/opcode interface and checks the responses.
//   - Sequences pseudo-random operands through every ALU opcode.
//   - Compresses each {result, zero} pair into a 32-bit MISR signature.
//   - Compares the final signature against a golden value.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/alu_bist_if.sv | 37 +++
 rtl/bist_lfsr32.sv | 56 +++++
 rtl/alu_bist.sv | 201 ++++++++++++++++++++
 tb/tb_alu_bist.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared CPU definitions used by the ALU self-test engine.
//   Contents:
//     - ALU opcode encodings ALU_ADD..ALU_SLTU (4-bit alu_control values)
//     - BIST constants: MISR polynomial and operand-B mask
//     - bist_state_t : BIST controller FSM states (exported for debug)
//     - lfsr_mode_t  : feedback form selector for bist_lfsr32
//     - helper functions for the LFSR / MISR steps and operand-B derivation
// -----------------------------------------------------------------------------
package cpu_pkg;

    // ALU opcode encodings as seen on alu_control
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Self-test constants
    localparam logic [31:0] BIST_MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] BIST_B_MASK    = 32'h5A5A_5A5A;

    typedef enum logic [1:0] {
        BIST_IDLE = 2'd0,
        BIST_RUN  = 2'd1,
        BIST_DONE = 2'd2
    } bist_state_t;

    typedef enum logic {
        LFSR_FIBONACCI = 1'b0,
        LFSR_GALOIS    = 1'b1
    } lfsr_mode_t;

    // Fibonacci step, taps 32/22/2/1
    function automatic logic [31:0] fib_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Galois shift-left step with data absorption
    function automatic logic [31:0] galois_step(input logic [31:0] m,
                                                input logic [31:0] poly,
                                                input logic [31:0] d);
        return {m[30:0], 1'b0} ^ (m[31] ? poly : 32'h0) ^ d;
    endfunction

    // Operand B is a half-word swap of operand A, scrambled with a fixed mask
    function automatic logic [31:0] bist_operand_b(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ BIST_B_MASK;
    endfunction

endpackage

// File: rtl/alu_bist_if.sv
// -----------------------------------------------------------------------------
// alu_bist_if
//   EX-stage ALU operand/opcode interface.
//   Signals:
//     alu_a, alu_b  32  operands, driven by the stimulus side
//     alu_control   4   opcode, driven by the stimulus side
//     alu_result    32  result, driven by the ALU (combinational)
//     alu_zero      1   zero flag, driven by the ALU
//   Modports:
//     master : stimulus/response side (the BIST engine)
//     slave  : the ALU
//   Handshake: none. The ALU is purely combinational; the master presents a
//   vector on one rising edge and samples result/zero on the next one.
// -----------------------------------------------------------------------------
interface alu_bist_if;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;

    modport master (
        output alu_a,
        output alu_b,
        output alu_control,
        input  alu_result,
        input  alu_zero
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_control,
        output alu_result,
        output alu_zero
    );
endinterface

// File: rtl/bist_lfsr32.sv
// -----------------------------------------------------------------------------
// bist_lfsr32
//   32-bit shift register with selectable feedback, used both as the operand
//   generator (Fibonacci, din tied to 0) and as the response compactor
//   (Galois MISR, din = absorbed data).
//   Parameters:
//     MODE       LFSR_FIBONACCI (taps 32/22/2/1) or LFSR_GALOIS (POLY)
//     POLY       Galois feedback polynomial
//     RESET_VAL  value taken on asynchronous reset
//   Ports:
//     clk       in   1   rising-edge clock
//     rst_n     in   1   asynchronous active-low reset
//     load      in   1   synchronous load of load_val (priority over en)
//     load_val  in   32  value to load
//     en        in   1   advance one step
//     din       in   32  data XORed into the next state
//     q         out  32  current state
// -----------------------------------------------------------------------------
module bist_lfsr32
    import cpu_pkg::*;
#(
    parameter lfsr_mode_t  MODE      = LFSR_FIBONACCI,
    parameter logic [31:0] POLY      = BIST_MISR_POLY,
    parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] q
);

    logic [31:0] q_next;

    always_comb begin
        q_next = q;
        if (MODE == LFSR_GALOIS) begin
            q_next = galois_step(q, POLY, din);
        end else begin
            q_next = fib_step(q) ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/alu_bist.sv
// -----------------------------------------------------------------------------
// alu_bist
//   Built-in self-test engine for the EX-stage ALU. On start it sweeps
//   NUM_VECTORS pseudo-random operand pairs through opcodes 0..NUM_OPS-1,
//   compacts every {result, zero} response into a 32-bit MISR and, at the end
//   of the run, compares the signature with GOLDEN_SIG.
//
//   Parameters:
//     NUM_VECTORS  vectors per run (>=1)
//     NUM_OPS      opcodes swept (wrap counter 0..NUM_OPS-1)
//     LFSR_SEED    operand LFSR seed (0 is replaced by 1)
//     GOLDEN_SIG   expected final signature
//   Ports:
//     clk          in   1   rising-edge clock
//     rst_n        in   1   asynchronous active-low reset
//     start        in   1   run request, honoured in IDLE/DONE only
//     busy         out  1   run in progress (exactly NUM_VECTORS cycles)
//     done         out  1   run finished, held until next start or reset
//     pass         out  1   valid while done; signature matched GOLDEN_SIG
//     signature    out  32  current MISR state
//     fsm_state    out  2   controller state, for debug/observation
//     err_inject   in   1   (ALU_BIST_ERRINJ_EN only) flip bit 0 of the
//                           absorbed response while high in RUN
//     alu          master modport of alu_bist_if (operands/opcode out,
//                  result/zero in)
//   Configuration macro: ALU_BIST_ERRINJ_EN (adds err_inject).
// -----------------------------------------------------------------------------
module alu_bist
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned NUM_OPS     = 10,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
    parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       signature,
    output bist_state_t       fsm_state,
`ifdef ALU_BIST_ERRINJ_EN
    input  logic              err_inject,
`endif
    alu_bist_if.master        alu
);

    localparam int          IDX_W    = $clog2(NUM_VECTORS + 1);
    localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h0000_0001 : LFSR_SEED;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_OP  = 4'(NUM_OPS - 1);

    bist_state_t      state, state_next;
    logic [IDX_W-1:0] idx, idx_next;

    logic             busy_next, done_next, pass_next;
    logic [31:0]      a_next, b_next;
    logic [3:0]       ctrl_next;

    logic             lfsr_load, lfsr_en;
    logic             misr_load, misr_en;
    logic [31:0]      lfsr_q;
    logic [31:0]      absorb;
    logic [31:0]      misr_next;

    assign fsm_state = state;

    // Response word absorbed into the MISR this cycle
`ifdef ALU_BIST_ERRINJ_EN
    assign absorb = alu.alu_result ^ {31'b0, alu.alu_zero ^ err_inject};
`else
    assign absorb = alu.alu_result ^ {31'b0, alu.alu_zero};
`endif

    // The operand LFSR runs one step ahead of the presented vector: on start
    // it is loaded with step(seed) while vector 0 is built from the seed
    // itself, so on every RUN edge lfsr_q already holds the next vector's
    // source and no combinational look-ahead port is needed.
    bist_lfsr32 #(
        .MODE      (LFSR_FIBONACCI),
        .POLY      (BIST_MISR_POLY),
        .RESET_VAL (SEED_EFF)
    ) u_operand_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .load_val (fib_step(SEED_EFF)),
        .en       (lfsr_en),
        .din      (32'h0),
        .q        (lfsr_q)
    );

    bist_lfsr32 #(
        .MODE      (LFSR_GALOIS),
        .POLY      (BIST_MISR_POLY),
        .RESET_VAL (32'h0)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (misr_load),
        .load_val (32'h0),
        .en       (misr_en),
        .din      (absorb),
        .q        (signature)
    );

    // Same step the MISR takes this edge; needed to decide pass together
    // with the final absorption.
    assign misr_next = galois_step(signature, BIST_MISR_POLY, absorb);

    // Next-state and output-register logic
    always_comb begin
        state_next = state;
        idx_next   = idx;
        busy_next  = busy;
        done_next  = done;
        pass_next  = pass;
        a_next     = alu.alu_a;
        b_next     = alu.alu_b;
        ctrl_next  = alu.alu_control;
        lfsr_load  = 1'b0;
        lfsr_en    = 1'b0;
        misr_load  = 1'b0;
        misr_en    = 1'b0;

        case (state)
            BIST_IDLE, BIST_DONE: begin
                if (start) begin
                    state_next = BIST_RUN;
                    idx_next   = '0;
                    busy_next  = 1'b1;
                    done_next  = 1'b0;
                    pass_next  = 1'b0;
                    a_next     = SEED_EFF;
                    b_next     = bist_operand_b(SEED_EFF);
                    ctrl_next  = 4'd0;
                    lfsr_load  = 1'b1;
                    misr_load  = 1'b1;
                end
            end

            BIST_RUN: begin
                misr_en = 1'b1;
                lfsr_en = 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = BIST_DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    pass_next  = (misr_next == GOLDEN_SIG);
                    a_next     = 32'h0;
                    b_next     = 32'h0;
                    ctrl_next  = 4'd0;
                end else begin
                    idx_next  = idx + IDX_W'(1);
                    a_next    = lfsr_q;
                    b_next    = bist_operand_b(lfsr_q);
                    // Opcode wrap counter: no divider needed for mod NUM_OPS
                    ctrl_next = (alu.alu_control == LAST_OP) ? 4'd0
                                                             : alu.alu_control + 4'd1;
                end
            end

            default: begin
                state_next = BIST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BIST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            alu.alu_a       <= 32'h0;
            alu.alu_b       <= 32'h0;
            alu.alu_control <= 4'd0;
        end else begin
            idx             <= idx_next;
            busy            <= busy_next;
            done            <= done_next;
            pass            <= pass_next;
            alu.alu_a       <= a_next;
            alu.alu_b       <= b_next;
            alu.alu_control <= ctrl_next;
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// -----------------------------------------------------------------------------
// tb_alu_bist
//   Bench for alu_bist. Three engines share clock and reset:
//     dut_short : NUM_VECTORS=10, reference ALU
//     dut_main  : NUM_VECTORS=256, GOLDEN_SIG from the bench model, reference ALU
//     dut_stuck : NUM_VECTORS=256, same golden, ALU with result[0] stuck at 1
//   With ALU_BIST_ERRINJ_EN defined, err_inject is exercised on dut_main.
// -----------------------------------------------------------------------------
module tb_alu_bist;
    import cpu_pkg::*;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    // Reference ALU
    function automatic logic [31:0] alu_fn(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [3:0]  op);
        logic [31:0] r;
        r = 32'h0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = $unsigned($signed(a) >>> b[4:0]);
            4'd8: r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            4'd9: r = (a < b) ? 32'h1 : 32'h0;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Signature expected after n vectors; stuck forces result bit 0 high
    function automatic logic [31:0] model_sig(input int n, input bit stuck);
        logic [31:0] l, m, a, b, r, d;
        logic        z;
        int          op;
        l  = SEED;
        m  = 32'h0;
        op = 0;
        for (int k = 0; k < n; k++) begin
            a = l;
            b = {l[15:0], l[31:16]} ^ 32'h5A5A_5A5A;
            r = alu_fn(a, b, 4'(op));
            if (stuck) r[0] = 1'b1;
            z = (r == 32'h0);
            d = r ^ {31'b0, z};
            m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C1_1DB7 : 32'h0) ^ d;
            l = lfsr_next(l);
            op = (op == 9) ? 0 : op + 1;
        end
        return m;
    endfunction

    localparam logic [31:0] MODEL_SIG = model_sig(256, 1'b0);

    logic clk;
    logic rst_n;
    logic start_short, start_main, start_stuck;
`ifdef ALU_BIST_ERRINJ_EN
    logic err_inject;
`endif

    logic        short_busy, short_done, short_pass;
    logic [31:0] short_sig;
    bist_state_t short_state;
    logic        main_busy, main_done, main_pass;
    logic [31:0] main_sig;
    bist_state_t main_state;
    logic        stuck_busy, stuck_done, stuck_pass;
    logic [31:0] stuck_sig;
    bist_state_t stuck_state;

    int checks = 0;
    int errors = 0;

    alu_bist_if if_short ();
    alu_bist_if if_main ();
    alu_bist_if if_stuck ();

    assign if_short.alu_result = alu_fn(if_short.alu_a, if_short.alu_b, if_short.alu_control);
    assign if_short.alu_zero   = (if_short.alu_result == 32'h0);
    assign if_main.alu_result  = alu_fn(if_main.alu_a, if_main.alu_b, if_main.alu_control);
    assign if_main.alu_zero    = (if_main.alu_result == 32'h0);
    assign if_stuck.alu_result = alu_fn(if_stuck.alu_a, if_stuck.alu_b, if_stuck.alu_control) | 32'h1;
    assign if_stuck.alu_zero   = (if_stuck.alu_result == 32'h0);

    alu_bist #(.NUM_VECTORS(10), .NUM_OPS(10), .LFSR_SEED(SEED), .GOLDEN_SIG(32'h0)) dut_short (
        .clk(clk), .rst_n(rst_n), .start(start_short), .busy(short_busy), .done(short_done),
        .pass(short_pass), .signature(short_sig), .fsm_state(short_state),
`ifdef ALU_BIST_ERRINJ_EN
        .err_inject(1'b0),
`endif
        .alu(if_short));

    alu_bist #(.NUM_VECTORS(256), .NUM_OPS(10), .LFSR_SEED(SEED), .GOLDEN_SIG(MODEL_SIG)) dut_main (
        .clk(clk), .rst_n(rst_n), .start(start_main), .busy(main_busy), .done(main_done),
        .pass(main_pass), .signature(main_sig), .fsm_state(main_state),
`ifdef ALU_BIST_ERRINJ_EN
        .err_inject(err_inject),
`endif
        .alu(if_main));

    alu_bist #(.NUM_VECTORS(256), .NUM_OPS(10), .LFSR_SEED(SEED), .GOLDEN_SIG(MODEL_SIG)) dut_stuck (
        .clk(clk), .rst_n(rst_n), .start(start_stuck), .busy(stuck_busy), .done(stuck_done),
        .pass(stuck_pass), .signature(stuck_sig), .fsm_state(stuck_state),
`ifdef ALU_BIST_ERRINJ_EN
        .err_inject(1'b0),
`endif
        .alu(if_stuck));

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers: pulse start across exactly one rising edge (returns at the
    // falling edge right after, where vector 0 is on the bus)
    task automatic pulse_main();
        @(negedge clk);
        start_main = 1'b1;
        @(negedge clk);
        start_main = 1'b0;
    endtask

    // Wait for dut_main done, counting busy cycles; bounded
    task automatic wait_main_done(output int busy_cycles, output bit timed_out);
        busy_cycles = 0;
        timed_out   = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (main_done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            if (main_busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        start_short = 1'b1;
        @(negedge clk);
        start_short = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({short_busy, short_done, short_pass} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/pass=%b want 000", {short_busy, short_done, short_pass});
        end
        checks++;
        if (if_short.alu_a !== 32'h0 || if_short.alu_b !== 32'h0 || if_short.alu_control !== 4'h0) begin
            errors++;
            $display("FAIL reset_alu_bus: got a=%h b=%h ctl=%h want zeros",
                     if_short.alu_a, if_short.alu_b, if_short.alu_control);
        end
        checks++;
        if (short_sig !== 32'h0) begin
            errors++;
            $display("FAIL reset_signature: got %h want 00000000", short_sig);
        end
        checks++;
        if (short_state !== BIST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", short_state, BIST_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        logic [31:0] l;
        logic [31:0] exp_sig;
        l       = SEED;
        exp_sig = model_sig(10, 1'b0);
        @(negedge clk);
        start_short = 1'b1;
        @(negedge clk);
        start_short = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (short_busy !== 1'b1 || short_done !== 1'b0) begin
                errors++;
                $display("FAIL seq_busy[%0d]: got busy=%b done=%b want 1 0", i, short_busy, short_done);
            end
            checks++;
            if (if_short.alu_control !== 4'(i)) begin
                errors++;
                $display("FAIL seq_opcode[%0d]: got %0d want %0d", i, if_short.alu_control, i);
            end
            checks++;
            if (if_short.alu_a !== l || if_short.alu_b !== ({l[15:0], l[31:16]} ^ 32'h5A5A_5A5A)) begin
                errors++;
                $display("FAIL seq_operands[%0d]: got a=%h b=%h want a=%h b=%h", i,
                         if_short.alu_a, if_short.alu_b, l, {l[15:0], l[31:16]} ^ 32'h5A5A_5A5A);
            end
            l = lfsr_next(l);
            @(negedge clk);
        end
        checks++;
        if (short_done !== 1'b1 || short_busy !== 1'b0) begin
            errors++;
            $display("FAIL seq_done: got busy=%b done=%b want 0 1", short_busy, short_done);
        end
        checks++;
        if (if_short.alu_a !== 32'h0 || if_short.alu_b !== 32'h0 || if_short.alu_control !== 4'h0) begin
            errors++;
            $display("FAIL seq_bus_idle: got a=%h b=%h ctl=%h want zeros",
                     if_short.alu_a, if_short.alu_b, if_short.alu_control);
        end
        checks++;
        if (short_sig !== exp_sig || short_pass !== (exp_sig == 32'h0)) begin
            errors++;
            $display("FAIL seq_signature: got sig=%h pass=%b want sig=%h pass=%b",
                     short_sig, short_pass, exp_sig, exp_sig == 32'h0);
        end
        // start held high in DONE restarts on the next edge
        start_short = 1'b1;
        @(negedge clk);
        start_short = 1'b0;
        checks++;
        if (short_busy !== 1'b1 || short_done !== 1'b0 || if_short.alu_a !== SEED || if_short.alu_control !== 4'h0) begin
            errors++;
            $display("FAIL restart_from_done: got busy=%b done=%b a=%h ctl=%h want 1 0 %h 0",
                     short_busy, short_done, if_short.alu_a, if_short.alu_control, SEED);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (short_done !== 1'b1 || short_sig !== exp_sig) begin
            errors++;
            $display("FAIL restart_signature: got done=%b sig=%h want 1 %h", short_done, short_sig, exp_sig);
        end
    endtask

    task automatic test_main_pass();
        int busy_cycles;
        bit timed_out;
        int drops;
        pulse_main();
        wait_main_done(busy_cycles, timed_out);
        checks++;
        if (timed_out || busy_cycles != 256) begin
            errors++;
            $display("FAIL main_busy_len: got %0d cycles (timeout=%0d) want 256", busy_cycles, timed_out);
        end
        checks++;
        if (main_pass !== 1'b1 || main_sig !== MODEL_SIG) begin
            errors++;
            $display("FAIL main_pass: got pass=%b sig=%h want 1 %h", main_pass, main_sig, MODEL_SIG);
        end
        drops = 0;
        repeat (100) begin
            @(negedge clk);
            if (main_done !== 1'b1 || main_pass !== 1'b1 || main_sig !== MODEL_SIG || if_main.alu_control !== 4'h0)
                drops++;
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL main_done_hold: got %0d bad cycles want 0", drops);
        end
    endtask

    task automatic test_stuck_alu();
        bit          finished;
        logic [31:0] exp_sig;
        exp_sig = model_sig(256, 1'b1);
        @(negedge clk);
        start_stuck = 1'b1;
        @(negedge clk);
        start_stuck = 1'b0;
        finished = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (stuck_done === 1'b1) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!finished || stuck_pass !== 1'b0) begin
            errors++;
            $display("FAIL stuck_pass: got done=%b pass=%b want 1 0", stuck_done, stuck_pass);
        end
        checks++;
        if (stuck_sig === MODEL_SIG || stuck_sig !== exp_sig) begin
            errors++;
            $display("FAIL stuck_signature: got %h want %h (golden %h)", stuck_sig, exp_sig, MODEL_SIG);
        end
    endtask

    task automatic test_restart_abort();
        int busy_cycles;
        bit timed_out;
        pulse_main();
        // Re-pulse start at cycles 3 and 5 of the run
        for (int i = 0; i < 7; i++) begin
            start_main = (i == 3 || i == 5);
            @(negedge clk);
        end
        start_main = 1'b0;
        checks++;
        if (main_busy !== 1'b1 || if_main.alu_control !== 4'd7) begin
            errors++;
            $display("FAIL ignore_start: got busy=%b ctl=%0d want 1 7", main_busy, if_main.alu_control);
        end
        wait_main_done(busy_cycles, timed_out);
        checks++;
        if (timed_out || busy_cycles != 249 || main_sig !== MODEL_SIG || main_pass !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start_sig: got busy=%0d sig=%h pass=%b want 249 %h 1",
                     busy_cycles, main_sig, main_pass, MODEL_SIG);
        end
        // Abort with reset at cycle 4
        pulse_main();
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (main_busy !== 1'b0 || main_sig !== 32'h0 || main_state !== BIST_IDLE) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b sig=%h state=%0d want 0 0 0", main_busy, main_sig, main_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_main();
        wait_main_done(busy_cycles, timed_out);
        checks++;
        if (timed_out || main_sig !== MODEL_SIG || main_pass !== 1'b1) begin
            errors++;
            $display("FAIL abort_rerun: got sig=%h pass=%b timeout=%0d want %h 1", main_sig, main_pass, timed_out, MODEL_SIG);
        end
    endtask

`ifdef ALU_BIST_ERRINJ_EN
    task automatic test_errinj();
        int busy_cycles;
        bit timed_out;
        pulse_main();
        repeat (10) @(negedge clk);
        err_inject = 1'b1;
        @(negedge clk);
        err_inject = 1'b0;
        wait_main_done(busy_cycles, timed_out);
        checks++;
        if (timed_out || main_pass !== 1'b0 || main_sig === MODEL_SIG) begin
            errors++;
            $display("FAIL errinj_detect: got pass=%b sig=%h want pass=0", main_pass, main_sig);
        end
        pulse_main();
        wait_main_done(busy_cycles, timed_out);
        checks++;
        if (timed_out || main_pass !== 1'b1 || main_sig !== MODEL_SIG) begin
            errors++;
            $display("FAIL errinj_clean: got pass=%b sig=%h want 1 %h", main_pass, main_sig, MODEL_SIG);
        end
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        start_short = 1'b0;
        start_main  = 1'b0;
        start_stuck = 1'b0;
`ifdef ALU_BIST_ERRINJ_EN
        err_inject  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_sequence();
        test_main_pass();
        test_stuck_alu();
        test_restart_abort();
`ifdef ALU_BIST_ERRINJ_EN
        test_errinj();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
